avm_data_master: RTL and testbench

- Data-side bus master placed directly downstream of the pipelined RISC-V core's MEM stage.
- Accepts the core's level-held read/write requests (address, write data) and runs them as Avalon-MM master transactions.
- Supports waitrequest and variable-latency readdatavalid.
- Returns read data plus a one-cycle done pulse that the core's read/write controls and enable logic use to release the pipeline.

---
 rtl/avm_master_pkg.sv | 25 ++
 rtl/avm_timeout_cnt.sv | 29 ++
 rtl/avm_data_master.sv | 148 ++++++++++++++
 tb/tb_avm_data_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/avm_master_pkg.sv
// Shared types and constants for the Avalon-MM data-side master.
// Contents: FSM state enum, fixed byte enable, word-align mask and the
// helper that sizes the read-timeout counter from its limit.
package avm_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_CMD,
      RESP
   } state_t;

   localparam logic [3:0]  BYTEEN_ALL = 4'hF;
   localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC;

   // Wide enough to hold the value 'limit' itself; never narrower than one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

   localparam int DEFAULT_TIMEOUT = 255;
   localparam int DEFAULT_CNT_W   = cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/avm_timeout_cnt.sv
// Read-response timeout counter: synchronous clear/enable up-counter.
// Ports: clk, rst (sync, active-high), clr, en -> cnt, tc.
// tc is high while cnt sits one below LIMIT, so an enabled cycle with tc set
// is the cycle in which the count reaches LIMIT.
module avm_timeout_cnt #(
   parameter int LIMIT = 255,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/avm_data_master.sv
// Data-side Avalon-MM master behind the core's MEM stage: turns level-held
// read/write requests into single outstanding Avalon transactions and returns
// read data with a one-cycle done pulse.
// Ports: CLK, RST (sync, active-high); core side req_rd/req_wr/req_addr/
// req_wdata -> rsp_rdata/rsp_done/rsp_err/proto_err; Avalon side avm_*.
module avm_data_master
   import avm_master_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rsp_rdata,
   output logic        rsp_done,
   output logic        rsp_err,
   output logic        proto_err,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   state_t           state;
   logic             armed;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt;

   // Counter restarts at read acceptance and runs only while waiting for data.
   assign cnt_clr = (state == RD_CMD) && !avm_waitrequest;
   assign cnt_en  = (state == RD_WAIT) && !avm_readdatavalid;

   avm_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES),
      .WIDTH (CNT_W)
   ) u_timeout_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (cnt_tc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         armed          <= 1'b1;
         rsp_rdata      <= '0;
         rsp_done       <= 1'b0;
         rsp_err        <= 1'b0;
         proto_err      <= 1'b0;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         avm_byteenable <= BYTEEN_ALL;
      end else begin
         rsp_done       <= 1'b0;
         rsp_err        <= 1'b0;
         avm_byteenable <= BYTEEN_ALL;

         if (req_rd && req_wr) begin
            proto_err <= 1'b1;
         end

         // The core keeps its request high through rsp_done; only an idle
         // cycle on both request lines allows the next transaction to start.
         if (!req_rd && !req_wr) begin
            armed <= 1'b1;
         end else if (state == RESP) begin
            armed <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (armed && (req_wr || req_rd)) begin
                  avm_address   <= req_addr & ADDR_MASK;
                  avm_writedata <= req_wdata;
                  if (req_wr) begin
                     avm_write <= 1'b1;
                     state     <= WR_CMD;
                  end else begin
                     avm_read  <= 1'b1;
                     state     <= RD_CMD;
                  end
               end
            end

            RD_CMD: begin
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  // Zero-latency slave: data arrives with the acceptance.
                  if (avm_readdatavalid) begin
                     rsp_rdata <= avm_readdata;
                     rsp_done  <= 1'b1;
                     state     <= RESP;
                  end else begin
                     state     <= RD_WAIT;
                  end
               end
            end

            RD_WAIT: begin
               if (avm_readdatavalid) begin
                  rsp_rdata <= avm_readdata;
                  rsp_done  <= 1'b1;
                  state     <= RESP;
               end else if (cnt_tc) begin
                  rsp_rdata <= ERR_RDATA;
                  rsp_done  <= 1'b1;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end

            WR_CMD: begin
               if (!avm_waitrequest) begin
                  avm_write <= 1'b0;
                  rsp_done  <= 1'b1;
                  state     <= RESP;
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avm_data_master.sv
module tb_avm_data_master;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_rd, req_wr;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] rsp_rdata;
   logic        rsp_done, rsp_err, proto_err;
   logic [31:0] avm_address;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   avm_data_master #(
      .TIMEOUT_CYCLES (TO),
      .ERR_RDATA      (32'h0000_0000)
   ) dut (
      .CLK               (clk),
      .RST               (rst),
      .req_rd            (req_rd),
      .req_wr            (req_wr),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_rdata         (rsp_rdata),
      .rsp_done          (rsp_done),
      .rsp_err           (rsp_err),
      .proto_err         (proto_err),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdata"},  rsp_rdata, 32'h0);
      chk({tag, "_done"},   32'(rsp_done), 32'h0);
      chk({tag, "_err"},    32'(rsp_err), 32'h0);
      chk({tag, "_proto"},  32'(proto_err), 32'h0);
      chk({tag, "_addr"},   avm_address, 32'h0);
      chk({tag, "_read"},   32'(avm_read), 32'h0);
      chk({tag, "_write"},  32'(avm_write), 32'h0);
      chk({tag, "_wdata"},  avm_writedata, 32'h0);
      chk({tag, "_be"},     32'(avm_byteenable), 32'hF);
   endtask

   initial begin
      int k;
      logic seen;

      rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      step(); step();
      chk_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Write, no wait states
      req_wr = 1'b1; req_addr = 32'h0000_1003; req_wdata = 32'hCAFE_F00D;
      step();
      chk("wr_n1_write", 32'(avm_write), 32'h1);
      chk("wr_n1_addr",  avm_address, 32'h0000_1000);
      chk("wr_n1_wdata", avm_writedata, 32'hCAFE_F00D);
      chk("wr_n1_done",  32'(rsp_done), 32'h0);
      step();
      chk("wr_n2_done",  32'(rsp_done), 32'h1);
      chk("wr_n2_write", 32'(avm_write), 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         seen = seen | avm_write | rsp_done;
      end
      chk("wr_no_reissue", 32'(seen), 32'h0);
      req_wr = 1'b0;
      step();

      // Read: 3 waitrequest cycles, data 2 cycles after acceptance
      req_rd = 1'b1; req_addr = 32'h0000_2004; avm_waitrequest = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rd_cmd%0d_read", i), 32'(avm_read), 32'h1);
         chk($sformatf("rd_cmd%0d_addr", i), avm_address, 32'h0000_2004);
         avm_waitrequest = (i == 3) ? 1'b0 : 1'b1;
         step();
      end
      avm_waitrequest = 1'b0;
      chk("rd_after_acc_read", 32'(avm_read), 32'h0);
      step();
      chk("rd_wait_done", 32'(rsp_done), 32'h0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h1234_5678;
      step();
      avm_readdatavalid = 1'b0; avm_readdata = '0;
      chk("rd_done",  32'(rsp_done), 32'h1);
      chk("rd_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_err",   32'(rsp_err), 32'h0);
      req_rd = 1'b0;
      step();

      // Read timeout
      req_rd = 1'b1; req_addr = 32'h0000_3000;
      step();
      chk("to_read", 32'(avm_read), 32'h1);
      k = 0;
      do begin
         step();
         k++;
      end while (!rsp_done && k < 100);
      chk("to_latency", 32'(k), 32'(TO + 1));
      chk("to_err",   32'(rsp_err), 32'h1);
      chk("to_rdata", rsp_rdata, 32'h0);
      req_rd = 1'b0;
      step();
      chk("to_err_pulse", 32'(rsp_err), 32'h0);
      avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
      step();
      avm_readdatavalid = 1'b0; avm_readdata = '0;
      step();
      chk("stale_rdata", rsp_rdata, 32'h0);
      chk("stale_done",  32'(rsp_done), 32'h0);

      // Read and write together
      req_rd = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_4008; req_wdata = 32'h1111_2222;
      step();
      chk("both_write", 32'(avm_write), 32'h1);
      chk("both_read",  32'(avm_read), 32'h0);
      chk("both_proto", 32'(proto_err), 32'h1);
      step();
      chk("both_done", 32'(rsp_done), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         seen = seen | avm_write | avm_read;
      end
      chk("both_single", 32'(seen), 32'h0);
      req_rd = 1'b0; req_wr = 1'b0;
      step();
      chk("proto_sticky", 32'(proto_err), 32'h1);

      // Reset during RD_WAIT
      req_rd = 1'b1; req_addr = 32'h0000_5000;
      step();
      step();
      chk("rst_pre_read", 32'(avm_read), 32'h0);
      rst = 1'b1;
      step();
      chk_reset_outputs("midrst");
      rst = 1'b0;
      step();
      chk("post_rst_read", 32'(avm_read), 32'h1);
      chk("post_rst_addr", avm_address, 32'h0000_5000);
      step();
      avm_readdatavalid = 1'b1; avm_readdata = 32'hABCD_0123;
      step();
      avm_readdatavalid = 1'b0; avm_readdata = '0;
      chk("post_rst_done",  32'(rsp_done), 32'h1);
      chk("post_rst_rdata", rsp_rdata, 32'hABCD_0123);

      // Back-to-back: held request must not reissue until dropped once
      step();
      chk("b2b_held1", 32'(avm_read), 32'h0);
      step();
      chk("b2b_held2", 32'(avm_read), 32'h0);
      req_rd = 1'b0;
      step();
      req_rd = 1'b1; req_addr = 32'h0000_6000;
      step();
      chk("b2b_read", 32'(avm_read), 32'h1);
      chk("b2b_addr", avm_address, 32'h0000_6000);
      avm_readdatavalid = 1'b1; avm_readdata = 32'h7777_8888;
      step();
      avm_readdatavalid = 1'b0; avm_readdata = '0;
      chk("zl_done",  32'(rsp_done), 32'h1);
      chk("zl_rdata", rsp_rdata, 32'h7777_8888);
      req_rd = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
